// File: rtl/ex_stage_mdu_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_mdu_if
// Description : Bundles the ID/EX operand/control inputs, the forwarding
//               sources and the EX/MEM outputs of the execute stage.
//               The master side is upstream/downstream logic; the slave
//               side is the execute stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_stage_mdu_if #(
  parameter int XLEN = 32
);
  // ID/EX latch contents
  logic [XLEN-1:0] Read_data1;
  logic [XLEN-1:0] Read_data2;
  logic [XLEN-1:0] im_ext;
  logic [XLEN-1:0] pc_in;
  logic [5:0]      func;
  logic [8:0]      ctrl_sig;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic            flush;

  // forwarding sources
  logic            mem_reg_write;
  logic            wb_reg_write;
  logic [4:0]      mem_rd;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] mem_result;
  logic [XLEN-1:0] wb_result;

  // EX/MEM latch and observation outputs
  logic            stall_out;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] write_data;
  logic [4:0]      dest;
  logic [3:0]      ctrl_out;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output Read_data1, Read_data2, im_ext, pc_in, func, ctrl_sig, rs, rt, rd, flush,
    output mem_reg_write, wb_reg_write, mem_rd, wb_rd, mem_result, wb_result,
    input  stall_out, alu_result, write_data, dest, ctrl_out, pc_out, hi, lo
  );

  modport slave (
    input  Read_data1, Read_data2, im_ext, pc_in, func, ctrl_sig, rs, rt, rd, flush,
    input  mem_reg_write, wb_reg_write, mem_rd, wb_rd, mem_result, wb_result,
    output stall_out, alu_result, write_data, dest, ctrl_out, pc_out, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/ex_stage_mdu.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_mdu
// Description : Execute stage with ALU, operand forwarding, an iterative
//               signed multiply/divide unit with HI/LO, and the EX/MEM latch.
//               Optional feature macro: EX_FORWARDING_EN (forwarding muxes).
//               MDU_CYCLES must equal XLEN (one result bit per iteration).
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage_mdu #(
  parameter int XLEN       = 32,
  parameter int MDU_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst,
  ex_stage_mdu_if.slave bus
);

  localparam int CW = $clog2(MDU_CYCLES);

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // operands
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b_reg;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_y;

  // MDU registers
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc;        // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opnd;       // mult: multiplicand magnitude; div: divisor magnitude
  logic [XLEN-1:0]   dividend;   // original signed dividend, for divide-by-zero result
  logic              is_div;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;

  // EX/MEM latch
  logic [XLEN-1:0] res_q;
  logic [XLEN-1:0] wd_q;
  logic [4:0]      dest_q;
  logic [3:0]      ctrl_q;
  logic [XLEN-1:0] pc_q;

  logic [1:0] alu_op;
  logic       is_md_op;
  logic       md_issue;
  logic       bubble;
  logic       last;

  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;
  logic [XLEN-1:0]   hi_fin;
  logic [XLEN-1:0]   lo_fin;

  logic unused_fwd;
  logic unused_misc;

`ifdef EX_FORWARDING_EN
  // Forwarding muxes: MEM stage beats WB stage, register 0 is never forwarded
  always_comb begin
    op_a = bus.Read_data1;
    if (bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == bus.rs))
      op_a = bus.mem_result;
    else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.rs))
      op_a = bus.wb_result;

    op_b_reg = bus.Read_data2;
    if (bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == bus.rt))
      op_b_reg = bus.mem_result;
    else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.rt))
      op_b_reg = bus.wb_result;
  end

  assign unused_fwd = 1'b0;
`else
  // Without forwarding the register file values are used as-is
  assign op_a     = bus.Read_data1;
  assign op_b_reg = bus.Read_data2;

  assign unused_fwd = ^{bus.rs, bus.mem_reg_write, bus.wb_reg_write, bus.mem_rd,
                        bus.wb_rd, bus.mem_result, bus.wb_result};
`endif

  assign op_b   = bus.ctrl_sig[4] ? bus.im_ext : op_b_reg;
  assign alu_op = bus.ctrl_sig[3:2];

  // ALU result for everything that retires in one cycle
  always_comb begin
    alu_y = '0;
    case (alu_op)
      2'b00: alu_y = op_a + op_b;
      2'b01: alu_y = op_a - op_b;
      2'b10: begin
        case (bus.func)
          F_ADD:   alu_y = op_a + op_b;
          F_SUB:   alu_y = op_a - op_b;
          F_AND:   alu_y = op_a & op_b;
          F_OR:    alu_y = op_a | op_b;
          F_SLT:   alu_y = ($signed(op_a) < $signed(op_b)) ? XLEN'(1) : '0;
          F_MFHI:  alu_y = hi_q;
          F_MFLO:  alu_y = lo_q;
          default: alu_y = '0;
        endcase
      end
      default: alu_y = op_a | op_b;
    endcase
  end

  assign is_md_op = (alu_op == 2'b10) && ((bus.func == F_MULT) || (bus.func == F_DIV));
  assign md_issue = (state == IDLE) && !bus.flush && is_md_op;
  assign bubble   = bus.flush || (state == BUSY) || md_issue;
  assign last     = (count == CW'(MDU_CYCLES - 1));

  // The core iterates on magnitudes; signs are re-applied on the final edge
  assign a_abs = op_a[XLEN-1] ? (~op_a + XLEN'(1)) : op_a;
  assign b_abs = op_b[XLEN-1] ? (~op_b + XLEN'(1)) : op_b;

  // One iteration: shift-add for mult, restoring subtract for div
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
    mul_next = {mul_sum, acc[XLEN-1:1]};

    // trial remainder keeps the bit shifted out of the top of the remainder
    div_diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, opnd};
    if (div_diff[XLEN+1])
      div_next = {acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], 1'b0};
    else
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    acc_step = is_div ? div_next : mul_next;
  end

  // Sign correction and special cases applied to the last iteration's value
  always_comb begin
    prod_fix = neg_q ? (~acc_step + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_step;
    q_fix    = neg_q ? (~acc_step[XLEN-1:0] + XLEN'(1)) : acc_step[XLEN-1:0];
    r_fix    = neg_r ? (~acc_step[2*XLEN-1:XLEN] + XLEN'(1)) : acc_step[2*XLEN-1:XLEN];
    hi_fin   = prod_fix[2*XLEN-1:XLEN];
    lo_fin   = prod_fix[XLEN-1:0];
    if (is_div) begin
      if (div_zero) begin
        hi_fin = dividend;
        lo_fin = '1;
      end else begin
        hi_fin = r_fix;
        lo_fin = q_fix;
      end
    end
  end

  // MDU state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // MDU next-state: start on an issued mult/div, finish after the last step
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (md_issue) state_next = BUSY;
      BUSY:    if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // MDU datapath: latch operands on issue, iterate while busy, write HI/LO at the end
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      dividend <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (md_issue) begin
      count    <= '0;
      is_div   <= (bus.func == F_DIV);
      acc      <= {{XLEN{1'b0}}, ((bus.func == F_DIV) ? a_abs : b_abs)};
      opnd     <= (bus.func == F_DIV) ? b_abs : a_abs;
      dividend <= op_a;
      neg_q    <= op_a[XLEN-1] ^ op_b[XLEN-1];
      neg_r    <= op_a[XLEN-1];
      div_zero <= (op_b == '0);
    end else if (state == BUSY) begin
      acc   <= acc_step;
      count <= count + CW'(1);
      if (last) begin
        count <= '0;
        hi_q  <= hi_fin;
        lo_q  <= lo_fin;
      end
    end
  end

  // EX/MEM latch: a bubble clears only result, destination and control
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      wd_q   <= '0;
      dest_q <= '0;
      ctrl_q <= '0;
      pc_q   <= '0;
    end else if (bubble) begin
      res_q  <= '0;
      dest_q <= '0;
      ctrl_q <= '0;
    end else begin
      res_q  <= alu_y;
      wd_q   <= op_b_reg;
      dest_q <= bus.ctrl_sig[1] ? bus.rd : bus.rt;
      ctrl_q <= bus.ctrl_sig[8:5];
      pc_q   <= bus.pc_in;
    end
  end

  assign bus.stall_out  = (state == BUSY);
  assign bus.alu_result = res_q;
  assign bus.write_data = wd_q;
  assign bus.dest       = dest_q;
  assign bus.ctrl_out   = ctrl_q;
  assign bus.pc_out     = pc_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;

  // branch bit belongs to the ID stage; carry bit of the trial subtract is never needed
  assign unused_misc = ^{bus.ctrl_sig[0], div_diff[XLEN], unused_fwd};

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage_mdu
// Description : Self-checking bench for ex_stage_mdu: a reference model of the
//               execute stage compared every cycle, plus literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage_mdu;

  logic clk = 1'b0;
  logic rst;
  bit   chk_en = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

`ifdef EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  ex_stage_mdu_if #(.XLEN(32)) bus ();

  ex_stage_mdu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_res, m_wd, m_pc, m_hi, m_lo, p_hi, p_lo;
  logic [4:0]  m_dest;
  logic [3:0]  m_ctrl;
  bit          m_busy;
  int          m_left;

  function automatic logic [31:0] fwd_m(input logic [4:0] r, input logic [31:0] d);
    if (FWD) begin
      if (bus.mem_reg_write && r != 5'd0 && bus.mem_rd == r) return bus.mem_result;
      if (bus.wb_reg_write && r != 5'd0 && bus.wb_rd == r) return bus.wb_result;
    end
    return d;
  endfunction

  function automatic logic [31:0] alu_m(input logic [1:0] op, input logic [5:0] f,
                                        input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd3: return a | b;
      default: case (f)
        6'h20: return a + b;
        6'h22: return a - b;
        6'h24: return a & b;
        6'h25: return a | b;
        6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h10: return m_hi;
        6'h12: return m_lo;
        default: return 32'd0;
      endcase
    endcase
  endfunction

  always @(posedge clk) begin
    logic [31:0] a, b, bre;
    logic signed [63:0] p;
    bit is_md;
    if (rst) begin
      m_res = 0; m_wd = 0; m_pc = 0; m_dest = 0; m_ctrl = 0;
      m_hi = 0; m_lo = 0; m_busy = 0; m_left = 0;
    end else if (m_busy) begin
      m_res = 0; m_dest = 0; m_ctrl = 0;
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_hi = p_hi; m_lo = p_lo;
      end
    end else begin
      a     = fwd_m(bus.rs, bus.Read_data1);
      bre   = fwd_m(bus.rt, bus.Read_data2);
      b     = bus.ctrl_sig[4] ? bus.im_ext : bre;
      is_md = (bus.ctrl_sig[3:2] == 2'b10) && (bus.func == 6'h18 || bus.func == 6'h1A);
      if (bus.flush || is_md) begin
        m_res = 0; m_dest = 0; m_ctrl = 0;
        if (!bus.flush) begin
          m_busy = 1; m_left = 32;
          if (bus.func == 6'h18) begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            p_hi = p[63:32]; p_lo = p[31:0];
          end else if (b == 32'd0) begin
            p_lo = 32'hFFFF_FFFF; p_hi = a;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            p_lo = 32'h8000_0000; p_hi = 32'd0;
          end else begin
            p_lo = $signed(a) / $signed(b);
            p_hi = $signed(a) % $signed(b);
          end
        end
      end else begin
        m_res  = alu_m(bus.ctrl_sig[3:2], bus.func, a, b);
        m_wd   = bre;
        m_dest = bus.ctrl_sig[1] ? bus.rd : bus.rt;
        m_ctrl = bus.ctrl_sig[8:5];
        m_pc   = bus.pc_in;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_alu_result", bus.alu_result, m_res);
      chk("m_write_data", bus.write_data, m_wd);
      chk("m_pc_out", bus.pc_out, m_pc);
      chk("m_dest", {27'd0, bus.dest}, {27'd0, m_dest});
      chk("m_ctrl_out", {28'd0, bus.ctrl_out}, {28'd0, m_ctrl});
      chk("m_stall", {31'd0, bus.stall_out}, {31'd0, m_busy});
      chk("m_hi", bus.hi, m_hi);
      chk("m_lo", bus.lo, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  task automatic nop;
    bus.ctrl_sig = 9'h000; bus.func = 6'h00; bus.flush = 1'b0;
  endtask

  task automatic alu_vec(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic src, input logic [31:0] imm,
                         input logic [31:0] exp, input string nm);
    bus.ctrl_sig = {1'b1, 3'b000, src, op, 1'b1, 1'b0};
    bus.func = f; bus.Read_data1 = a; bus.Read_data2 = b; bus.im_ext = imm;
    tick;
    at_neg;
    chk(nm, bus.alu_result, exp);
  endtask

  task automatic run_md(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                        input logic [5:0] nf, input logic [8:0] nctrl,
                        input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    int n;
    bus.ctrl_sig = 9'h008; bus.func = f; bus.Read_data1 = a; bus.Read_data2 = b;
    bus.rs = 5'd1; bus.rt = 5'd2;
    tick;
    bus.ctrl_sig = nctrl; bus.func = nf; bus.rd = 5'd5;
    n = 0;
    at_neg;
    while (bus.stall_out && n < 40) begin
      n++;
      at_neg;
    end
    chk({nm, "_stall_cycles"}, n, 32);
    chk({nm, "_hi"}, bus.hi, ehi);
    chk({nm, "_lo"}, bus.lo, elo);
  endtask

  initial begin
    rst = 1'b1;
    bus.Read_data1 = 0; bus.Read_data2 = 0; bus.im_ext = 0; bus.pc_in = 0;
    bus.func = 0; bus.ctrl_sig = 0; bus.rs = 0; bus.rt = 0; bus.rd = 0; bus.flush = 0;
    bus.mem_reg_write = 0; bus.wb_reg_write = 0; bus.mem_rd = 0; bus.wb_rd = 0;
    bus.mem_result = 0; bus.wb_result = 0;
    tick;
    chk_en = 1'b1;
    tick;
    at_neg;
    chk("reset_alu_result", bus.alu_result, 32'd0);
    chk("reset_stall", {31'd0, bus.stall_out}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    chk("reset_pc_out", bus.pc_out, 32'd0);

    // plain add
    rst = 1'b0;
    bus.rs = 5'd1; bus.rt = 5'd2; bus.rd = 5'd3; bus.pc_in = 32'h0000_0100;
    alu_vec(2'b10, 6'h20, 32'd5, 32'd7, 1'b0, 32'd0, 32'd12, "add_5_7");
    chk("add_dest", {27'd0, bus.dest}, 32'd3);
    chk("add_ctrl_out", {28'd0, bus.ctrl_out}, 32'h8);
    chk("add_pc_out", bus.pc_out, 32'h0000_0100);
    chk("add_write_data", bus.write_data, 32'd7);

    // other ALU functions
    alu_vec(2'b10, 6'h22, 32'd10, 32'd3, 1'b0, 32'd0, 32'd7, "sub");
    alu_vec(2'b10, 6'h24, 32'hF0F0, 32'hFF00, 1'b0, 32'd0, 32'hF000, "and");
    alu_vec(2'b10, 6'h25, 32'hF0F0, 32'h0F00, 1'b0, 32'd0, 32'hFFF0, "or");
    alu_vec(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd1, "slt_neg_lt_pos");
    alu_vec(2'b10, 6'h2A, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, "slt_pos_lt_neg");
    alu_vec(2'b00, 6'h00, 32'd100, 32'd9, 1'b1, 32'hFFFF_FFFC, 32'h60, "addi_imm");
    alu_vec(2'b01, 6'h00, 32'd5, 32'd9, 1'b0, 32'd0, 32'hFFFF_FFFC, "sub_aluop01");
    alu_vec(2'b11, 6'h00, 32'h1200, 32'd0, 1'b1, 32'h0034, 32'h1234, "ori");
    alu_vec(2'b10, 6'h3F, 32'd5, 32'd5, 1'b0, 32'd0, 32'd0, "unknown_func");
    alu_vec(2'b10, 6'h20, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0, "add_wrap");

    // forwarding priority
    bus.rs = 5'd4; bus.rt = 5'd0;
    bus.mem_reg_write = 1; bus.wb_reg_write = 1;
    bus.mem_rd = 5'd4; bus.wb_rd = 5'd4;
    bus.mem_result = 32'hAA; bus.wb_result = 32'hBB;
    alu_vec(2'b10, 6'h20, 32'h11, 32'd0, 1'b0, 32'd0, FWD ? 32'hAA : 32'h11, "fwd_mem_priority");
    bus.mem_rd = 5'd0;
    alu_vec(2'b10, 6'h20, 32'h11, 32'd0, 1'b0, 32'd0, FWD ? 32'hBB : 32'h11, "fwd_wb");
    bus.mem_reg_write = 0; bus.wb_reg_write = 0; bus.wb_rd = 5'd0;

    // mult followed by mflo
    run_md(32'hFFFF_FFFD, 32'd7, 6'h18, 6'h12, 9'h10A, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3_7");
    at_neg;
    chk("mflo_after_mult", bus.alu_result, 32'hFFFF_FFEB);
    nop;

    // divides
    run_md(32'hFFFF_FFF9, 32'd2, 6'h1A, 6'h00, 9'h000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    run_md(32'd9, 32'd0, 6'h1A, 6'h00, 9'h000, 32'd9, 32'hFFFF_FFFF, "div_9_0");
    run_md(32'h8000_0000, 32'hFFFF_FFFF, 6'h1A, 6'h00, 9'h000, 32'd0, 32'h8000_0000, "div_min_m1");
    run_md(32'd100, 32'hFFFF_FFF9, 6'h1A, 6'h00, 9'h000, 32'd2, 32'hFFFF_FFF2, "div_100_m7");
    run_md(32'h8000_0000, 32'h8000_0000, 6'h18, 6'h00, 9'h000, 32'h4000_0000, 32'd0, "mult_min_min");

    // flush with a mult while idle: nothing issues
    bus.ctrl_sig = 9'h008; bus.func = 6'h18; bus.flush = 1'b1;
    tick;
    at_neg;
    chk("flush_idle_stall", {31'd0, bus.stall_out}, 32'd0);
    chk("flush_idle_ctrl", {28'd0, bus.ctrl_out}, 32'd0);
    chk("flush_idle_dest", {27'd0, bus.dest}, 32'd0);
    nop;

    // flush in the middle of a running mult does not disturb it
    bus.ctrl_sig = 9'h008; bus.func = 6'h18; bus.Read_data1 = 32'd1000; bus.Read_data2 = 32'hFFFF_FFFD;
    tick;
    nop;
    repeat (10) tick;
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    at_neg;
    chk("flush_busy_stall_held", {31'd0, bus.stall_out}, 32'd1);
    begin
      int n;
      n = 0;
      while (bus.stall_out && n < 40) begin
        n++;
        at_neg;
      end
      chk("flush_busy_done", {31'd0, bus.stall_out}, 32'd0);
    end
    chk("flush_busy_hi", bus.hi, 32'hFFFF_FFFF);
    chk("flush_busy_lo", bus.lo, 32'hFFFF_F448);

    // reset in the middle of a mult
    bus.ctrl_sig = 9'h008; bus.func = 6'h18; bus.Read_data1 = 32'd6; bus.Read_data2 = 32'd7;
    tick;
    nop;
    repeat (15) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    at_neg;
    chk("rst_mid_stall", {31'd0, bus.stall_out}, 32'd0);
    chk("rst_mid_hi", bus.hi, 32'd0);
    chk("rst_mid_lo", bus.lo, 32'd0);
    run_md(32'd6, 32'd7, 6'h18, 6'h00, 9'h000, 32'd0, 32'd42, "mult_after_rst");

    nop;
    repeat (3) tick;
    at_neg;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
